// File: rtl/rfid_pkg.sv
// Shared RC522 constants, FSM state type and the SPI read-address formatter.
package rfid_pkg;

  // RC522 register addresses (6-bit register space)
  localparam logic [5:0] REG_COMMAND     = 6'h01;
  localparam logic [5:0] REG_FIFO_DATA   = 6'h09;
  localparam logic [5:0] REG_FIFO_LEVEL  = 6'h0A;
  localparam logic [5:0] REG_BIT_FRAMING = 6'h0D;
  localparam logic [5:0] REG_VERSION     = 6'h37;

  // RC522 command codes written to CommandReg
  localparam logic [3:0] CMD_IDLE       = 4'h0;
  localparam logic [3:0] CMD_TRANSCEIVE = 4'hC;
  localparam logic [3:0] CMD_SOFT_RESET = 4'hF;

  // MSB of the SPI address byte selects read (1) or write (0)
  localparam logic RD_BIT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } rd_state_e;

  // RC522 SPI address byte: {R/W, addr[5:0], 0}
  function automatic logic [7:0] fmt_read_addr(input logic [5:0] addr);
    return {RD_BIT, addr, 1'b0};
  endfunction

endpackage

// File: rtl/rfid_spi_byte.sv
// Mode-0 8-bit full-duplex SPI shifter with a CLK_DIV half-period prescaler.
// A load on the final falling edge chains the next byte with no gap.
module rfid_spi_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_system,
  input  logic       reset_system,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       byte_end
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active_q;
  logic [DW-1:0] div_q;
  logic [3:0]    half_q;
  logic [6:0]    tx_q;
  logic [7:0]    rx_q;
  logic          sck_q;
  logic          mosi_q;
  logic          done_q;
  logic          tick_s;

  assign tick_s    = (div_q == DW'(CLK_DIV - 1));
  // Asserted in the last cycle of a byte; the next clock edge is its final falling edge
  assign byte_end  = active_q && tick_s && (half_q == 4'd15);
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign rx_byte   = rx_q;
  assign byte_done = done_q;

  // Prescaler, SCK generation, MISO capture on rise and MOSI update on fall
  always_ff @(posedge clk_system or negedge reset_system) begin
    if (!reset_system) begin
      active_q <= 1'b0;
      div_q    <= '0;
      half_q   <= 4'd0;
      tx_q     <= 7'd0;
      rx_q     <= 8'h00;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        active_q <= 1'b1;
        div_q    <= '0;
        half_q   <= 4'd0;
        sck_q    <= 1'b0;
        tx_q     <= tx_byte[6:0];
        mosi_q   <= tx_byte[7];
      end else if (active_q) begin
        if (tick_s) begin
          div_q  <= '0;
          half_q <= half_q + 4'd1;
          if (!half_q[0]) begin
            sck_q <= 1'b1;
            rx_q  <= {rx_q[6:0], miso};
            done_q <= (half_q == 4'd14);
          end else begin
            sck_q <= 1'b0;
            if (half_q == 4'd15) begin
              active_q <= 1'b0;
              mosi_q   <= tx_byte[7];
            end else begin
              tx_q   <= {tx_q[5:0], 1'b0};
              mosi_q <= tx_q[6];
            end
          end
        end else begin
          div_q <= div_q + DW'(1);
        end
      end else begin
        // Idle: pre-present the MSB so MOSI is valid while CS is set up
        sck_q  <= 1'b0;
        mosi_q <= tx_byte[7];
      end
    end
  end

endmodule

// File: rtl/rfid_readreg.sv
// RC522 SPI register reader: address byte, N data bytes clocked in on MISO,
// with CS setup/hold/gap timing and range checking of the burst length.
module rfid_readreg
  import rfid_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk_system,
  input  logic             reset_system,
  input  logic             start,
  input  logic [5:0]       reg_addr,
  input  logic [CNT_W-1:0] num_bytes,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  input  logic             miso,
  output logic             mosi,
  output logic             clk_spi,
  output logic             cs
);

  localparam int TW = $clog2(CLK_DIV + 1);

  rd_state_e      state_q;
  logic [TW-1:0]  tmr_q;
  logic [7:0]     addr_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W:0] idx_q;
  logic [CNT_W:0] idx_d;
  logic           busy_q, done_q, err_q, rd_valid_q, cs_q;
  logic [7:0]     rd_data_q;
  logic           start_ok_s, last_byte_s, load_s;
  logic [7:0]     tx_byte_s, rx_byte_s;
  logic           byte_done_s, byte_end_s;

  assign start_ok_s  = (num_bytes != '0) && (num_bytes <= CNT_W'(MAX_BYTES));
  assign last_byte_s = (idx_q == {1'b0, num_q});
  // Index of the byte that the next load will start
  assign idx_d       = (state_q == ST_SHIFT) ? idx_q + (CNT_W + 1)'(1) : '0;
  assign tx_byte_s   = (((state_q == ST_SETUP) || (state_q == ST_SHIFT)) &&
                        (idx_d < {1'b0, num_q})) ? addr_q : 8'h00;
  assign load_s      = ((state_q == ST_SETUP) && (tmr_q == TW'(CLK_DIV))) ||
                       ((state_q == ST_SHIFT) && byte_end_s && !last_byte_s);

  rfid_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk_system   (clk_system),
    .reset_system (reset_system),
    .load         (load_s),
    .tx_byte      (tx_byte_s),
    .miso         (miso),
    .sck          (clk_spi),
    .mosi         (mosi),
    .rx_byte      (rx_byte_s),
    .byte_done    (byte_done_s),
    .byte_end     (byte_end_s)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign cs       = cs_q;

  // Transaction FSM: framing, CS timing, byte sequencing and registered status
  always_ff @(posedge clk_system or negedge reset_system) begin
    if (!reset_system) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      addr_q     <= 8'h00;
      num_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      cs_q       <= 1'b1;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      // Byte 0 clocks in while the address goes out and is discarded
      if (byte_done_s && (state_q == ST_SHIFT) && (idx_q != '0)) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rx_byte_s;
      end else begin
        rd_data_q  <= rd_data_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (start && start_ok_s) begin
            state_q <= ST_SETUP;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            addr_q  <= fmt_read_addr(reg_addr);
            num_q   <= num_bytes;
            idx_q   <= '0;
            tmr_q   <= '0;
          end else if (start) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          cs_q <= 1'b0;
          if (tmr_q == TW'(CLK_DIV)) begin
            state_q <= ST_SHIFT;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        ST_SHIFT: begin
          if (byte_end_s && last_byte_s) begin
            state_q <= ST_HOLD;
            tmr_q   <= '0;
          end else if (byte_end_s) begin
            idx_q <= idx_d;
          end else begin
            idx_q <= idx_q;
          end
        end
        ST_HOLD: begin
          if (tmr_q == TW'(CLK_DIV - 1)) begin
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_GAP;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        ST_GAP: begin
          if (tmr_q == TW'(CLK_DIV - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cs_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rfid_readreg.sv
// Scoreboard bench for rfid_readreg with a behavioural RC522 SPI slave.
module tb_rfid_readreg;

  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 16;
  localparam int CNT_W     = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [5:0]       reg_addr = 6'd0;
  logic [CNT_W-1:0] num_bytes = '0;
  logic             miso;
  logic             busy, rd_valid, done, err, mosi, clk_spi, cs;
  logic [7:0]       rd_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rd[$];
  logic       exp_done[$];

  logic [7:0] resp[0:16];
  int fall_cnt = 0, fall_base = 0, rise_cnt = 0, rise_base = 0, cs_falls = 0;
  logic [7:0] mosi_sh = 8'h00;

  rfid_readreg #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk_system(clk), .reset_system(rst_n), .start(start), .reg_addr(reg_addr),
    .num_bytes(num_bytes), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .miso(miso), .mosi(mosi), .clk_spi(clk_spi), .cs(cs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RC522 model: MISO shifts on SCK falling edges, first bit valid when CS falls
  always @(negedge clk_spi) fall_cnt++;
  always @(negedge cs) begin
    fall_base = fall_cnt;
    rise_base = rise_cnt;
    cs_falls++;
  end
  always @* begin
    int bi;
    bi = fall_cnt - fall_base;
    if (bi >= 0 && bi < 17 * 8) miso = resp[bi / 8][7 - (bi % 8)];
    else miso = 1'b0;
  end

  // MOSI monitor: assemble bytes on SCK rising edges and score them
  always @(posedge clk_spi) begin
    if (!cs) begin
      mosi_sh = {mosi_sh[6:0], mosi};
      rise_cnt++;
      if (((rise_cnt - rise_base) % 8) == 0) begin
        if (exp_mosi.size() == 0) check("mosi_extra_byte", mosi_sh, 32'hFFFF_FFFF);
        else check("mosi_byte", mosi_sh, exp_mosi.pop_front());
      end
    end
  end

  // rd_valid / done monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", done, 0);
        else check("err_at_done", err, exp_done.pop_front());
      end
    end
  end

  task automatic start_read(input logic [5:0] a, input logic [CNT_W-1:0] n);
    @(negedge clk);
    reg_addr = a; num_bytes = n; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Latency counted in cycles from the accepting edge; cs-low cycles counted alongside
  task automatic wait_done(output int lat, output int low);
    int cyc;
    bit ok;
    cyc = 0; low = 0; ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      cyc++;
      if (!cs) low++;
      if (done) begin ok = 1'b1; break; end
    end
    check("done_seen", {31'd0, ok}, 1);
    lat = cyc - 1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
  endtask

  task automatic test_version_read();
    int lat, low, bn;
    resp[0] = 8'h5A; resp[1] = 8'h92;
    exp_mosi.push_back(8'hEE); exp_mosi.push_back(8'h00);
    exp_rd.push_back(8'h92);
    exp_done.push_back(1'b0);
    start_read(6'h37, 5'd1);
    wait_done(lat, low);
    check("latency_n1", lat, 137);
    check("cs_low_n1", low, 136);
    wait_idle(bn);
    check("busy_fall_after_done", bn, 4);
    check("rd_data_hold", rd_data, 8'h92);
  endtask

  initial begin
    int lat, low, bn, csf0;
    for (int i = 0; i < 17; i++) resp[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_clk_spi", clk_spi, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err", err, 0);
    check("rst_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read of VersionReg
    test_version_read();

    // Burst of five FIFODataReg bytes
    resp[0] = 8'h5A; resp[1] = 8'hDE; resp[2] = 8'hAD; resp[3] = 8'hBE;
    resp[4] = 8'hEF; resp[5] = 8'h22;
    for (int i = 0; i < 5; i++) exp_mosi.push_back(8'h92);
    exp_mosi.push_back(8'h00);
    exp_rd.push_back(8'hDE); exp_rd.push_back(8'hAD); exp_rd.push_back(8'hBE);
    exp_rd.push_back(8'hEF); exp_rd.push_back(8'h22);
    exp_done.push_back(1'b0);
    start_read(6'h09, 5'd5);
    wait_done(lat, low);
    check("latency_n5", lat, 393);
    wait_idle(bn);

    // Longest legal burst
    resp[0] = 8'hC3;
    for (int k = 1; k <= 16; k++) begin
      resp[k] = 8'h30 + 8'(k);
      exp_rd.push_back(8'h30 + 8'(k));
      exp_mosi.push_back(8'h92);
    end
    exp_mosi.push_back(8'h00);
    exp_done.push_back(1'b0);
    start_read(6'h09, 5'd16);
    wait_done(lat, low);
    check("latency_n16", lat, 1097);
    check("cs_low_n16", low, 1096);
    wait_idle(bn);

    // Out-of-range lengths: immediate done+err, no CS activity
    csf0 = cs_falls;
    exp_done.push_back(1'b1);
    start_read(6'h37, 5'd0);
    @(negedge clk);
    check("range0_done", done, 1);
    check("range0_err", err, 1);
    check("range0_busy", busy, 0);
    repeat (3) @(negedge clk);
    exp_done.push_back(1'b1);
    start_read(6'h37, 5'd17);
    @(negedge clk);
    check("range17_done", done, 1);
    check("range17_err", err, 1);
    repeat (20) @(negedge clk);
    check("range_no_cs", cs_falls, csf0);

    // start while busy is ignored; err clears on the accepted start
    resp[0] = 8'h5A; resp[1] = 8'h92;
    exp_mosi.push_back(8'hEE); exp_mosi.push_back(8'h00);
    exp_rd.push_back(8'h92);
    exp_done.push_back(1'b0);
    start_read(6'h37, 5'd1);
    @(negedge clk);
    check("err_cleared", err, 0);
    repeat (40) @(negedge clk);
    reg_addr = 6'h09; num_bytes = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, low);
    wait_idle(bn);
    repeat (10) @(negedge clk);
    check("busy_after_ignored_start", busy, 0);

    // Reset during byte 1 while SCK is high
    exp_mosi.push_back(8'hEE);
    start_read(6'h37, 5'd1);
    repeat (75) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs", cs, 1);
    check("midrst_clk_spi", clk_spi, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    test_version_read();

    repeat (5) @(negedge clk);
    check("mosi_queue_empty", exp_mosi.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
